// File: rtl/pmod_keypad_emu.sv
// Keypad-side emulator for a 4x4 PMOD keypad: plays scripted key presses with
// contact bounce, hold time and release gap onto the active-low Row lines.
module pmod_keypad_emu #(
    parameter int         CLK_PER_MS  = 100000,
    parameter int         BOUNCE_CYC  = 2000,
    parameter int         BOUNCE_STEP = 250,
    parameter int         GAP_MS      = 2,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_key,
    input  logic [7:0] req_hold_ms,
    input  logic       abort,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       busy,
    output logic       done,
    output logic       contact
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int BW = (BOUNCE_CYC > 0) ? $clog2(BOUNCE_CYC + 1) : 1;
    localparam int SW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_MS - 1);
    localparam logic [BW-1:0] BNC_LAST  = BW'(BOUNCE_CYC - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(BOUNCE_STEP - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(GAP_MS - 1);
    localparam logic          NO_BOUNCE = (BOUNCE_CYC == 0);
    localparam logic          GAP_NONE  = (GAP_MS == 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } state_t;

    // Returns {column index, active-low row mask} for a key code.
    function automatic logic [5:0] key_map(input logic [3:0] key);
        case (key)
            4'h1:    key_map = {2'd0, 4'b0111};
            4'h4:    key_map = {2'd0, 4'b1011};
            4'h7:    key_map = {2'd0, 4'b1101};
            4'h0:    key_map = {2'd0, 4'b1110};
            4'h2:    key_map = {2'd1, 4'b0111};
            4'h5:    key_map = {2'd1, 4'b1011};
            4'h8:    key_map = {2'd1, 4'b1101};
            4'hF:    key_map = {2'd1, 4'b1110};
            4'h3:    key_map = {2'd2, 4'b0111};
            4'h6:    key_map = {2'd2, 4'b1011};
            4'h9:    key_map = {2'd2, 4'b1101};
            4'hE:    key_map = {2'd2, 4'b1110};
            4'hA:    key_map = {2'd3, 4'b0111};
            4'hB:    key_map = {2'd3, 4'b1011};
            4'hC:    key_map = {2'd3, 4'b1101};
            4'hD:    key_map = {2'd3, 4'b1110};
            default: key_map = {2'd0, 4'b1111};
        endcase
    endfunction

    // Galois LFSR step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_galois(input logic [7:0] v);
        lfsr_galois = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    state_t          state_r;
    logic [1:0]      col_idx_r;
    logic [3:0]      mask_r;
    logic [7:0]      hold_r;
    logic [7:0]      tick_r;
    logic [PW-1:0]   pre_r;
    logic [BW-1:0]   bnc_r;
    logic [SW-1:0]   step_r;
    logic [7:0]      lfsr_r;
    logic [7:0]      lfsr_nxt_s;
    logic [3:0]      col_sync_r;

    assign lfsr_nxt_s = lfsr_galois(lfsr_r);

    // Press sequencer: handshake, bounce windows, ms-tick hold and gap timing.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            contact   <= 1'b0;
            col_idx_r <= 2'd0;
            mask_r    <= 4'b1111;
            hold_r    <= 8'd0;
            tick_r    <= 8'd0;
            pre_r     <= PW'(0);
            bnc_r     <= BW'(0);
            step_r    <= SW'(0);
            lfsr_r    <= LFSR_SEED;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    contact <= 1'b0;
                    if (req_valid) begin
                        {col_idx_r, mask_r} <= key_map(req_key);
                        hold_r    <= (req_hold_ms == 8'd0) ? 8'd1 : req_hold_ms;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        pre_r     <= PW'(0);
                        tick_r    <= 8'd0;
                        bnc_r     <= BW'(0);
                        step_r    <= SW'(0);
                        if (NO_BOUNCE) begin
                            state_r <= HOLD;
                            contact <= 1'b1;
                        end else begin
                            state_r <= BOUNCE_IN;
                            contact <= lfsr_r[0];
                        end
                    end
                end
                BOUNCE_IN, BOUNCE_OUT: begin
                    if (abort) begin
                        state_r <= GAP;
                        contact <= 1'b0;
                        pre_r   <= PW'(0);
                        tick_r  <= 8'd0;
                        bnc_r   <= BW'(0);
                        step_r  <= SW'(0);
                        done    <= GAP_NONE;
                    end else begin
                        if (step_r == STEP_LAST) begin
                            step_r  <= SW'(0);
                            lfsr_r  <= lfsr_nxt_s;
                            contact <= lfsr_nxt_s[0];
                        end else begin
                            step_r  <= step_r + SW'(1);
                            contact <= lfsr_r[0];
                        end
                        // Window end overrides the bounce contact chosen above.
                        if (bnc_r == BNC_LAST) begin
                            bnc_r  <= BW'(0);
                            pre_r  <= PW'(0);
                            tick_r <= 8'd0;
                            if (state_r == BOUNCE_IN) begin
                                state_r <= HOLD;
                                contact <= 1'b1;
                            end else begin
                                state_r <= GAP;
                                contact <= 1'b0;
                                done    <= GAP_NONE;
                            end
                        end else begin
                            bnc_r <= bnc_r + BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_r <= GAP;
                        contact <= 1'b0;
                        pre_r   <= PW'(0);
                        tick_r  <= 8'd0;
                        bnc_r   <= BW'(0);
                        step_r  <= SW'(0);
                        done    <= GAP_NONE;
                    end else if (pre_r == PRE_LAST) begin
                        pre_r <= PW'(0);
                        if (tick_r == hold_r - 8'd1) begin
                            tick_r <= 8'd0;
                            bnc_r  <= BW'(0);
                            step_r <= SW'(0);
                            if (NO_BOUNCE) begin
                                state_r <= GAP;
                                contact <= 1'b0;
                                done    <= GAP_NONE;
                            end else begin
                                state_r <= BOUNCE_OUT;
                                contact <= lfsr_r[0];
                            end
                        end else begin
                            tick_r <= tick_r + 8'd1;
                        end
                    end else begin
                        pre_r <= pre_r + PW'(1);
                    end
                end
                GAP: begin
                    contact <= 1'b0;
                    if (GAP_NONE) begin
                        state_r   <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (pre_r == PRE_LAST) begin
                        pre_r <= PW'(0);
                        if (tick_r == GAP_LAST) begin
                            tick_r    <= 8'd0;
                            state_r   <= IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            tick_r <= tick_r + 8'd1;
                        end
                    end else begin
                        pre_r <= pre_r + PW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    contact   <= 1'b0;
                end
            endcase
        end
    end

    // Column capture and registered row return (two-cycle Col-to-Row path).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_sync_r <= 4'b1111;
            Row        <= 4'b1111;
        end else begin
            col_sync_r <= Col;
            if (contact && (col_sync_r[2'd3 - col_idx_r] == 1'b0)) begin
                Row <= mask_r;
            end else begin
                Row <= 4'b1111;
            end
        end
    end

endmodule
